// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY-side responder: decodes management frames sampled from an
// asynchronous MDC, serves read data from a register file or ID constants, and commits writes.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd0,
  parameter logic [15:0] ID1      = 16'h0141,
  parameter logic [15:0] ID2      = 16'h0CC2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic        busy,
  output logic        wr_strobe,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data
);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StSt      = 4'd1;
  localparam logic [3:0] StOp      = 4'd2;
  localparam logic [3:0] StPhyad   = 4'd3;
  localparam logic [3:0] StRegad   = 4'd4;
  localparam logic [3:0] StTa      = 4'd5;
  localparam logic [3:0] StWdata   = 4'd6;
  localparam logic [3:0] StRdata   = 4'd7;
  localparam logic [3:0] StDiscard = 4'd8;

  logic [2:0]  mdc_sync_q;
  logic [1:0]  mdio_sync_q;
  logic        mdc_rise, mdc_fall, bit_in;

  logic [3:0]  state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  phyad_q, phyad_d;
  logic [4:0]  regad_q, regad_d;
  logic [15:0] wshift_q, wshift_d;
  logic [15:0] rshift_q, rshift_d;
  logic        rd_done_q, rd_done_d;
  logic        oe_q, oe_d;
  logic        o_q, o_d;
  logic        wr_commit;
  logic [15:0] regs_q [32];

  // Third mdc stage is only for edge detection; data and mdc share a two-flop latency.
  assign mdc_rise = mdc_sync_q[1] & ~mdc_sync_q[2];
  assign mdc_fall = ~mdc_sync_q[1] & mdc_sync_q[2];
  assign bit_in   = mdio_sync_q[1];

  assign mdio_o  = o_q;
  assign mdio_oe = oe_q;
  assign busy    = (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    pre_cnt_d = pre_cnt_q;
    op_d      = op_q;
    phyad_d   = phyad_q;
    regad_d   = regad_q;
    wshift_d  = wshift_q;
    rshift_d  = rshift_q;
    rd_done_d = rd_done_q;
    oe_d      = oe_q;
    o_d       = o_q;
    wr_commit = 1'b0;
    if (mdc_rise) begin
      case (state_q)
        StIdle: begin
          if (bit_in) begin
            if (pre_cnt_q != 6'd32) pre_cnt_d = pre_cnt_q + 6'd1;
          end else if (pre_cnt_q == 6'd32) begin
            state_d   = StSt;
            pre_cnt_d = 6'd0;
          end else begin
            pre_cnt_d = 6'd0;
          end
        end
        StSt: begin
          bit_cnt_d = 5'd0;
          state_d   = bit_in ? StOp : StIdle;
        end
        StOp: begin
          op_d      = {op_q[0], bit_in};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd1) begin
            bit_cnt_d = 5'd0;
            state_d   = (op_d == 2'b10 || op_d == 2'b01) ? StPhyad : StIdle;
          end
        end
        StPhyad: begin
          phyad_d   = {phyad_q[3:0], bit_in};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd4) begin
            bit_cnt_d = 5'd0;
            state_d   = StRegad;
          end
        end
        StRegad: begin
          regad_d   = {regad_q[3:0], bit_in};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd4) begin
            bit_cnt_d = 5'd0;
            if (phyad_q != PHY_ADDR) begin
              state_d = StDiscard;
            end else begin
              state_d = StTa;
              if (regad_d == 5'd2)      rshift_d = ID1;
              else if (regad_d == 5'd3) rshift_d = ID2;
              else                      rshift_d = regs_q[regad_d];
            end
          end
        end
        StTa: begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd1) begin
            bit_cnt_d = 5'd0;
            rd_done_d = 1'b0;
            state_d   = (op_q == 2'b10) ? StRdata : StWdata;
          end
        end
        StWdata: begin
          wshift_d  = {wshift_q[14:0], bit_in};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd15) begin
            wr_commit = 1'b1;
            state_d   = StIdle;
          end
        end
        StRdata: begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd15) rd_done_d = 1'b1;
        end
        StDiscard: begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd17) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (mdc_fall) begin
      if (state_q == StTa && bit_cnt_q == 5'd1 && op_q == 2'b10) begin
        oe_d = 1'b1;
        o_d  = 1'b0;
      end else if (state_q == StRdata) begin
        // The fall after DATA[0] was sampled ends the turnaround-free drive window.
        if (rd_done_q) begin
          oe_d    = 1'b0;
          o_d     = 1'b0;
          state_d = StIdle;
        end else begin
          o_d      = rshift_q[15];
          rshift_d = {rshift_q[14:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '0;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      pre_cnt_q   <= '0;
      op_q        <= '0;
      phyad_q     <= '0;
      regad_q     <= '0;
      wshift_q    <= '0;
      rshift_q    <= '0;
      rd_done_q   <= 1'b0;
      oe_q        <= 1'b0;
      o_q         <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[1:0], mdc};
      mdio_sync_q <= {mdio_sync_q[0], mdio_i};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      op_q        <= op_d;
      phyad_q     <= phyad_d;
      regad_q     <= regad_d;
      wshift_q    <= wshift_d;
      rshift_q    <= rshift_d;
      rd_done_q   <= rd_done_d;
      oe_q        <= oe_d;
      o_q         <= o_d;
      wr_strobe   <= wr_commit;
      if (wr_commit) begin
        wr_addr <= regad_q;
        wr_data <= wshift_d;
        if (regad_q != 5'd2 && regad_q != 5'd3) regs_q[regad_q] <= wshift_d;
      end
    end
  end

endmodule

// File: doc/mdio_phy_responder.md
MDIO_PHY_RESPONDER -- requirements
Module: mdio_phy_responder

Interface
REQ-001 The block SHALL have parameter PHY_ADDR, default 5'd0: the PHY address this responder answers to.
REQ-002 The block SHALL have parameter ID1, default 16'h0141: read-only value of register 2.
REQ-003 The block SHALL have parameter ID2, default 16'h0CC2: read-only value of register 3.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock; reset reset, asynchronous, active-high; clock clk.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port mdc, input, 1 bit: MDIO management clock, asynchronous to clk.
REQ-007 The block SHALL have port mdio_i, input, 1 bit: sampled MDIO line.
REQ-008 The block SHALL have port mdio_o, output, 1 bit: MDIO drive value.
REQ-009 The block SHALL have port mdio_oe, output, 1 bit: MDIO drive enable; the top level ties the pad to Z when this is low.
REQ-010 The block SHALL have port busy, output, 1 bit: high from ST detection to the end of the frame.
REQ-011 The block SHALL have port wr_strobe, output, 1 bit: one-clk pulse when a register write commits.
REQ-012 The block SHALL have port wr_addr, output, 5 bits: register address of the last committed write.
REQ-013 The block SHALL have port wr_data, output, 16 bits: data of the last committed write.

Function
REQ-014 The block SHALL synchronise mdc and mdio_i through two flip-flops each and detect mdc rising and falling edges in the clk domain; clk SHALL be at least 4x the mdc frequency.
REQ-015 The block SHALL sample mdio_i only on detected mdc rising edges, MSB first, using the frame: preamble, ST=01, OP (10 read, 01 write), PHYAD[4:0], REGAD[4:0], TA (2 bits), DATA[15:0].
REQ-016 The block SHALL implement states IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, DISCARD, with a 5-bit bit counter shared across fields.
REQ-017 In IDLE the block SHALL count consecutive 1 samples up to a saturating 32; a 0 sample with count <32 SHALL clear the count; a 0 sample with count =32 SHALL enter ST as the first ST bit.
REQ-018 In ST the block SHALL require the next sample to be 1; otherwise it SHALL return to IDLE with the count cleared.
REQ-019 After OP the block SHALL return to IDLE with the count cleared if OP is 00 or 11.
REQ-020 After REGAD, if PHYAD differs from PHY_ADDR, the block SHALL enter DISCARD, never assert mdio_oe, and return to IDLE after 18 more rising edges (TA + data).
REQ-021 On an address-matched read, the block SHALL assert mdio_oe with mdio_o=0 on the mdc falling edge that follows the first TA sample, then on each following falling edge drive DATA bits 15 down to 0.
REQ-022 The block SHALL deassert mdio_oe on the first mdc falling edge after DATA[0] has been driven for a full mdc period, then return to IDLE.
REQ-023 mdio_o and mdio_oe SHALL be registered and SHALL change no later than 4 clk cycles after the mdc edge on the mdc pin.
REQ-024 The read data SHALL be latched at the end of REGAD: ID1 for register 2, ID2 for register 3, and the register-file entry for all other addresses.
REQ-025 On an address-matched write, the block SHALL ignore the TA bits and shift in 16 data bits.
REQ-026 On the 16th data sample of a write, the block SHALL update the register file (except registers 2 and 3), load wr_addr and wr_data, and pulse wr_strobe for exactly one clk.
REQ-027 A write to register 2 or 3 SHALL still pulse wr_strobe but SHALL leave the register value unchanged.
REQ-028 busy SHALL rise on ST entry and fall on return to IDLE.
REQ-029 A frame aborted by ST or OP errors SHALL leave the register file and the wr_* outputs unchanged.
REQ-030 After any completed frame the block SHALL require a new 32-bit preamble before accepting the next frame.

Reset
REQ-031 Asserting reset SHALL immediately force mdio_oe=0, mdio_o=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, state IDLE and preamble count 0, including mid-frame.
REQ-032 Asserting reset SHALL clear all writable registers to 16'h0000.

Verification
REQ-033 Bench: 32 ones, write reg 0 = 16'h1140, then 32 ones, read reg 0 -> wr_strobe one pulse with wr_addr=0 and wr_data=16'h1140; read returns 16'h1140 with TA second bit 0.
REQ-034 Bench: read reg 2 and reg 3 -> 16'h0141 and 16'h0CC2; write 16'hFFFF to reg 2, then read reg 2 -> still 16'h0141.
REQ-035 Bench: frame with PHYAD=5'd1 against PHY_ADDR=0 -> mdio_oe stays 0 for the whole frame and no wr_strobe.
REQ-036 Bench: 31-bit preamble followed by a valid read -> no response; the next frame with a 32-bit preamble -> normal response.
REQ-037 Bench: write all 32 registers with the reset-table values (e.g. reg 17 = 16'h8110, reg 27 = 16'h848B), then read all 32 back -> every writable register matches, and registers 2 and 3 return their ID values.
REQ-038 Bench: assert reset during RDATA bit 8 -> mdio_oe=0 at once; a following read of the previously written register returns 16'h0000.
